pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Next-PC generator feeding the 20-bit PC register (pc_next -> PCin, PCOut -> pc_cur).
//  The PC register loads every clock, so this block drives the full next value each cycle: boot vector,
//  sequential increment, hold on fetch stall, or redirect (branch/jump/call/return).
//  Also presents the current PC to instruction fetch via a valid/ready handshake.
//  Also owns a small return-address stack (RAS).
// PARAMETERS
//  RESET_VECTOR  20'h00000  PC value loaded after reset
//  INC_STEP      20'd1      sequential PC increment
//  RAS_DEPTH     4          return-address stack entries (power of 2, >=2)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous active-low reset (0 = reset)
//  pc_cur       in   20  current PC (PC register output)
//  pc_next      out  20  next PC (PC register input)
//  fetch_valid  out  1   pc_cur is a valid fetch address
//  fetch_ready  in   1   fetch unit accepts pc_cur this cycle
//  branch_en    in   1   take relative branch
//  branch_off   in   20  two's-complement branch offset
//  jump_en      in   1   absolute jump
//  jump_addr    in   20  jump/call target
//  call_en      in   1   call: push return address, go to jump_addr
//  ret_en       in   1   return: pop RAS, go to popped address
//  ras_empty    out  1   RAS holds no entries
//  ras_full     out  1   RAS holds RAS_DEPTH entries
//  ras_err      out  1   1-cycle pulse: overflow push or empty pop
// BEHAVIOUR
//  Reset:
//   - reset==0 at posedge -> state=BOOT, RAS count=0, ras_err=0.
//   - While reset==0: pc_next=RESET_VECTOR, fetch_valid=0.
//  Reset values: fetch_valid=0, ras_empty=1, ras_full=0, ras_err=0.
//  FSM states: BOOT, RUN, STALL, FLUSH. All outputs registered except pc_next and fetch_valid,
//   which are decoded from state + inputs.
//  BOOT:
//   - pc_next=RESET_VECTOR, fetch_valid=0.
//   - -> RUN. The PC register holds RESET_VECTOR in the first RUN cycle.
//  RUN / STALL: fetch_valid=1, unless a redirect is present that cycle.
//   - No redirect, fetch_ready=1: pc_next = pc_cur+INC_STEP (mod 2^20, wraps FFFFF->00000); -> RUN.
//   - No redirect, fetch_ready=0: pc_next=pc_cur; -> STALL.
//   - fetch_valid, once high, must not drop until accepted. The sole exception is a redirect.
//  Redirect:
//   - Any of ret_en/call_en/jump_en/branch_en high in RUN or STALL.
//   - Priority: ret > call > jump > branch; lower-priority requests that cycle are ignored.
//   - Redirect cycle: fetch_valid=0 (pending fetch squashed), pc_next=target; -> FLUSH.
//   - branch target = pc_cur + branch_off (mod 2^20).
//   - jump target = jump_addr.
//   - call target = jump_addr; pushes pc_cur+INC_STEP (mod 2^20).
//   - ret target = RAS top; pops.
//  FLUSH:
//   - fetch_valid=0, pc_next=pc_cur; -> RUN.
//   - Redirect inputs are ignored in BOOT and FLUSH.
//  RAS:
//   - Circular LIFO. Push when full overwrites the oldest entry and pulses ras_err; count stays RAS_DEPTH.
//   - ret when empty: no redirect; treated as the non-redirect case (advance/hold per fetch_ready);
//     ras_err pulses; state follows the non-redirect rule.
//   - ras_err asserts the cycle after the offending request for exactly 1 cycle.
//   - ras_empty/ras_full reflect the count after the update (registered).
//  Reset mid-operation: wins over every other input; RAS contents are discarded.
// TESTING
//  - Release reset; ready=1: fetch_valid 0,0(BOOT),1; pc_cur runs 00000,00001,00002...
//  - pc_cur=00010, ready=0 for 3 cycles: pc_next=00010, fetch_valid=1 held; ready=1 -> pc_next=00011.
//  - pc_cur=00020, branch_en, off=20'hFFFF0:
//    -> fetch_valid=0, pc_next=00010; FLUSH bubble; then fetch at 00010.
//  - call@00100 (jump_addr=00400), then ret@00405: pc goes to 00400, then 00101; ras_empty 1->0->1.
//  - 5 calls with RAS_DEPTH=4 -> ras_err pulse on 5th; then 5 rets:
//    4 return the newest addresses, 5th pulses ras_err with no redirect.
//  - pc_cur=FFFFF, ready=1 -> pc_next=00000; branch+jump+ret same cycle with empty RAS -> jump taken.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC generator for the 20-bit PC register: boot vector, increment, stall hold and
// redirects (branch/jump/call/return), with a fetch valid/ready handshake and a circular RAS.
module pc_sequencer #(
    parameter logic [19:0] RESET_VECTOR = 20'h00000,
    parameter logic [19:0] INC_STEP     = 20'd1,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [19:0] i_pc_cur,
    output logic [19:0] o_pc_next,
    output logic        o_fetch_valid,
    input  logic        i_fetch_ready,
    input  logic        i_branch_en,
    input  logic [19:0] i_branch_off,
    input  logic        i_jump_en,
    input  logic [19:0] i_jump_addr,
    input  logic        i_call_en,
    input  logic        i_ret_en,
    output logic        o_ras_empty,
    output logic        o_ras_full,
    output logic        o_ras_err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [19:0]   r_ras [RAS_DEPTH];
    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_ras_err;
    logic          r_empty;
    logic          r_full;

    logic          w_active;
    logic          w_ret_take;
    logic          w_ret_bad;
    logic          w_call_take;
    logic          w_redirect;
    logic          w_count_full;
    logic [PW-1:0] w_top_idx;
    logic [19:0]   w_pc_inc;

    assign w_active     = (r_state == RUN) || (r_state == STALL);
    assign w_count_full = (r_count == CW'(RAS_DEPTH));
    // A return on an empty stack is not a redirect; lower-priority requests still apply.
    assign w_ret_take   = w_active && i_ret_en && (r_count != '0);
    assign w_ret_bad    = w_active && i_ret_en && (r_count == '0);
    assign w_call_take  = w_active && !w_ret_take && i_call_en;
    assign w_redirect   = w_ret_take || (w_active && (i_call_en || i_jump_en || i_branch_en));
    assign w_top_idx    = r_wp - PW'(1);
    assign w_pc_inc     = i_pc_cur + INC_STEP;

    always_comb begin
        o_pc_next     = RESET_VECTOR;
        o_fetch_valid = 1'b0;
        w_state_next  = r_state;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN, STALL: begin
                if (w_redirect) begin
                    w_state_next = FLUSH;
                    if (w_ret_take)
                        o_pc_next = r_ras[w_top_idx];
                    else if (i_call_en || i_jump_en)
                        o_pc_next = i_jump_addr;
                    else
                        o_pc_next = i_pc_cur + i_branch_off;
                end else begin
                    o_fetch_valid = 1'b1;
                    if (i_fetch_ready) begin
                        o_pc_next    = w_pc_inc;
                        w_state_next = RUN;
                    end else begin
                        o_pc_next    = i_pc_cur;
                        w_state_next = STALL;
                    end
                end
            end
            FLUSH: begin
                o_pc_next    = i_pc_cur;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
        if (!i_reset) begin
            o_pc_next     = RESET_VECTOR;
            o_fetch_valid = 1'b0;
            w_state_next  = BOOT;
        end
    end

    // Count saturates at RAS_DEPTH: an overflowing push just overwrites the oldest slot.
    always_comb begin
        w_count_next = r_count;
        if (w_ret_take)
            w_count_next = r_count - CW'(1);
        else if (w_call_take && !w_count_full)
            w_count_next = r_count + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= BOOT;
            r_wp      <= '0;
            r_count   <= '0;
            r_ras_err <= 1'b0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_ras_err <= w_ret_bad || (w_call_take && w_count_full);
            r_empty   <= (w_count_next == '0);
            r_full    <= (w_count_next == CW'(RAS_DEPTH));
            if (w_ret_take)
                r_wp <= r_wp - PW'(1);
            else if (w_call_take)
                r_wp <= r_wp + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset && w_call_take)
            r_ras[r_wp] <= w_pc_inc;
    end

    assign o_ras_empty = r_empty;
    assign o_ras_full  = r_full;
    assign o_ras_err   = r_ras_err;

endmodule
